shift_cmd_sequencer: RTL
========================

Name: shift_cmd_sequencer

Overview:
Command-queue front end that sits directly upstream of the 8-bit barrel shifter register and drives its load/rshift/lshift/shiftnum/inbit/in controls.
- Accepts {data, direction, amount, fill} commands over a valid/ready interface and buffers them in a small FIFO.
- Loads each command's data into the shifter, then splits shift amounts up to 15 into per-cycle chunks of at most 7.
- Captures the shifter's output and returns it over a valid/ready result interface.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of two, minimum 2.
AMT_W, 4, width of the requested shift amount; maximum request 2^AMT_W-1.

Ports:
clk  in  1  rising-edge clock, shared with the shifter
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_data  in  8  value to load
cmd_dir  in  1  0 = right shift, 1 = left shift
cmd_amt  in  AMT_W  total shift distance
cmd_fill  in  1  bit shifted in
sh_load  out  1  to shifter load
sh_rshift  out  1  to shifter rshift
sh_lshift  out  1  to shifter lshift
sh_shiftnum  out  3  to shifter shiftnum
sh_inbit  out  1  to shifter inbit
sh_in  out  8  to shifter in
sh_out  in  8  shifter registered output
res_valid  out  1  result available
res_data  out  8  shifted result
res_ready  in  1  result consumer ready

Behaviour:
- Reset (async assert, sync-released by the user): FIFO empty, state IDLE. All sh_* outputs are 0, res_valid is 0, res_data is 0, and cmd_ready is 1. A reset mid-operation abandons the current command and all queued commands.
- Handshake rules:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - A result transfers on an edge where res_valid && res_ready.
  - Offered data must be held stable while valid is high and ready is low.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, RESULT.
  - IDLE: on FIFO non-empty, pop the head into working registers (dir, remaining = amt, fill), then go to LOAD.
  - LOAD: one cycle. sh_load=1, sh_in=data. Next state is SHIFT if remaining != 0, else CAPTURE.
  - SHIFT: chunk = min(remaining, 7). Drive sh_rshift=~dir, sh_lshift=dir, sh_shiftnum=chunk, sh_inbit=fill; sh_load=0. remaining -= chunk. Stay in SHIFT while remaining after the update != 0, else go to CAPTURE.
  - CAPTURE: all sh_* strobes are 0. Register sh_out into res_data and set res_valid. Go to RESULT.
  - RESULT: hold res_valid/res_data until res_ready. On transfer, clear res_valid and go to IDLE. If the FIFO is non-empty, pop in the same cycle and go straight to LOAD (no IDLE bubble).
- Only one sh_* strobe is ever high in a cycle; sh_shiftnum is never 0 while a shift strobe is high.
- Latency: from the first IDLE cycle with a command pending to res_valid high is 1 + 1 + ceil(amt/7) + 1 cycles.
  - amt=0: 3 cycles.
  - amt=15: shift chunks 7, 7, 1.
- FIFO boundary conditions:
  - Full: cmd_ready=0.
  - Push and pop in the same cycle while full: only the pop happens, because cmd_ready was already low.
  - Push and pop in the same cycle while empty: the command is not visible to the FSM until the next cycle (no bypass).
  - Pointers wrap modulo CMD_DEPTH.
- Back-pressure: the FSM stalls in RESULT indefinitely. The shifter is not strobed during the stall, so sh_out is stable.

Optional Feature:
Macro SHIFT_SEQ_ROTATE_EN.
- Defined:
  - Adds input port cmd_rot (1 bit), stored in the FIFO alongside each command.
  - Rotate commands shift 1 bit per SHIFT cycle (sh_shiftnum=1).
  - sh_inbit = sh_out[0] for a right rotate, sh_out[7] for a left rotate.
  - Latency becomes 3 + amt cycles. amt is taken modulo 8 only if the result is identical; the full count is still issued.
- Undefined: no cmd_rot port, and all commands are logical shifts with fill.

Decomposition:
- Package shift_seq_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, CAPTURE, RESULT);
  - command struct {data[7:0], dir, amt[AMT_W-1:0], fill, and rot if the macro is defined};
  - constant MAX_CHUNK=7.
- One sub-module, shift_cmd_fifo: synchronous FIFO with registered storage, full/empty flags, and a parameterized depth.

Test Plan:
1. cmd data=0xB5, dir=R, amt=3, fill=0 -> LOAD, SHIFT(3); res_data=0x16; res_valid 4 cycles after the command reaches IDLE.
2. cmd data=0x81, dir=L, amt=15, fill=1 -> shifts 7, 7, 1 on sh_shiftnum; res_data=0xFF; latency 6.
3. amt=0, data=0x5A -> no shift strobe ever; res_data=0x5A; latency 3.
4. Push 5 commands back-to-back with res_ready=0 and CMD_DEPTH=4 -> cmd_ready drops after the FIFO fills. Then assert res_ready -> results emerge in order, each subsequent LOAD directly follows its RESULT handshake.
5. Assert rst_n=0 mid-SHIFT with 2 commands queued -> res_valid=0, all sh_* strobes 0, cmd_ready=1 immediately. No stale results after release.
6. (SHIFT_SEQ_ROTATE_EN) data=0x81, rot=1, dir=R, amt=1 -> sh_inbit=1 with sh_shiftnum=1; res_data=0xC0.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift command sequencer.
//   state_e   : sequencer FSM states
//   cmd_t     : one queued command {data, dir, amt, fill[, rot]}
//   MAX_CHUNK : largest distance the downstream shifter moves in one cycle
//   CMD_AMT_W : width of the queued amount field
// Macro SHIFT_SEQ_ROTATE_EN adds the rot field to cmd_t.
package shift_seq_pkg;

  localparam int unsigned MAX_CHUNK = 7;
  localparam int unsigned CMD_AMT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    RESULT
  } state_e;

  typedef struct packed {
    logic [7:0]           data;
    logic                 dir;
    logic [CMD_AMT_W-1:0] amt;
    logic                 fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic                 rot;
`endif
  } cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo: synchronous FIFO with registered storage.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers only)
//   push, din   : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   dout        : head entry (valid while !empty)
//   full, empty : occupancy flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module shift_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    dout = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: command-queue front end for the 8-bit barrel shifter.
//   cmd_*     : command valid/ready input {data, dir, amt, fill[, rot]}
//   sh_*      : shifter controls (load, rshift, lshift, shiftnum, inbit, in)
//   sh_out    : shifter registered output, captured as the result
//   res_*     : result valid/ready output
// Macro SHIFT_SEQ_ROTATE_EN adds cmd_rot: rotate one bit per SHIFT cycle,
// feeding the bit leaving the shifter back in as sh_inbit.
// AMT_W must not exceed shift_seq_pkg::CMD_AMT_W (width of the queued field).
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned AMT_W     = CMD_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  output logic             sh_load,
  output logic             sh_rshift,
  output logic             sh_lshift,
  output logic [2:0]       sh_shiftnum,
  output logic             sh_inbit,
  output logic [7:0]       sh_in,
  input  logic [7:0]       sh_out,
  output logic             res_valid,
  output logic [7:0]       res_data,
  input  logic             res_ready
);

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             fill_q, fill_d;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q, rot_d;
`endif
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;

  cmd_t             cmd_in, head;
  logic             fifo_full, fifo_empty, pop;
  logic [2:0]       chunk;
  logic [AMT_W-1:0] step;

  always_comb begin
    cmd_in      = '0;
    cmd_in.data = cmd_data;
    cmd_in.dir  = cmd_dir;
    cmd_in.amt  = CMD_AMT_W'(cmd_amt);
    cmd_in.fill = cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_in.rot  = cmd_rot;
`endif
  end

  shift_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d       = rot_q;
`endif
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    sh_load     = 1'b0;
    sh_rshift   = 1'b0;
    sh_lshift   = 1'b0;
    sh_shiftnum = '0;
    sh_inbit    = 1'b0;
    sh_in       = '0;

    if (rem_q > AMT_W'(MAX_CHUNK)) chunk = 3'(MAX_CHUNK);
    else                           chunk = 3'(rem_q);
    step = AMT_W'(chunk);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_load = 1'b1;
        sh_in   = data_q;
        state_d = (rem_q != '0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        sh_rshift   = !dir_q;
        sh_lshift   = dir_q;
        sh_shiftnum = chunk;
        sh_inbit    = fill_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        // Rotates move one bit per cycle so the wrapped bit is always the
        // single bit falling off the current shifter output.
        if (rot_q) begin
          sh_shiftnum = 3'd1;
          sh_inbit    = dir_q ? sh_out[7] : sh_out[0];
          step        = AMT_W'(1);
        end
`endif
        rem_d   = rem_q - step;
        state_d = (rem_d != '0) ? SHIFT : CAPTURE;
      end
      CAPTURE: begin
        res_valid_d = 1'b1;
        res_data_d  = sh_out;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          // Pop on the handshake itself so the next LOAD follows with no IDLE cycle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      data_d = head.data;
      dir_d  = head.dir;
      rem_d  = AMT_W'(head.amt);
      fill_d = head.fill;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_d  = head.rot;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dir_q       <= 1'b0;
      rem_q       <= '0;
      fill_q      <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q       <= 1'b0;
`endif
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q       <= rot_d;
`endif
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule
